// File: rtl/cache_bus_pkg.sv
// Shared types and default widths for the cache bus master and its helpers.
package cache_bus_pkg;

    localparam int unsigned ADDR_W_DEF         = 8;
    localparam int unsigned DATA_W_DEF         = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bus_timeout_counter.sv
// Watchdog for the REQ phase: counts enabled cycles since load and flags the
// LIMIT-th one. Only instantiated when BUS_TIMEOUT_EN is defined.
module bus_timeout_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(LIMIT) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (enable && !expire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_bus_master.sv
// Single-outstanding bus master between a cache controller and a bus arbiter,
// with snoop-driven invalidation. Optional watchdog: define BUS_TIMEOUT_EN.
module cache_bus_master
    import cache_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_req_ready,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              cpu_resp_stale,
    output logic              cpu_resp_err,
    output logic              bus_access,
    output logic              cache_write,
    output logic [ADDR_W-1:0] read_address,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    input  logic              finish,
    input  logic              snoop_flag,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              inv_valid,
    output logic [ADDR_W-1:0] inv_addr
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cache_bus_master: TIMEOUT_CYCLES must be at least 1");
    end

    bus_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              stale_q, stale_d;
    logic              inv_valid_q, inv_valid_d;
    logic [ADDR_W-1:0] inv_addr_q, inv_addr_d;
    logic              accept;
    logic              in_req;
    logic              in_resp;
    logic              timeout_expire;

    assign in_req  = (state_q == REQ);
    assign in_resp = (state_q == RESP);
    assign accept  = (state_q == IDLE) && cpu_req_valid;

`ifdef BUS_TIMEOUT_EN
    logic err_q, err_d;

    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .enable (in_req),
        .expire (timeout_expire)
    );

    assign cpu_resp_err = in_resp && err_q;
`else
    assign timeout_expire = 1'b0;
    assign cpu_resp_err   = 1'b0;
`endif

    // NOTE: every signal gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        stale_d     = stale_q;
`ifdef BUS_TIMEOUT_EN
        err_d       = err_q;
`endif
        inv_valid_d = snoop_flag;
        inv_addr_d  = snoop_flag ? snoop_addr : '0;

        case (state_q)
            IDLE: begin
                if (cpu_req_valid) begin
                    state_d = REQ;
                    we_d    = cpu_req_we;
                    addr_d  = cpu_req_addr;
                    wdata_d = cpu_req_wdata;
                    rdata_d = '0;
                end
            end
            REQ: begin
                // A remote write to the line being filled makes the fill stale.
                if (!we_q && snoop_flag && (snoop_addr == addr_q)) begin
                    stale_d = 1'b1;
                end
                if (finish) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : read_data;
                end else if (timeout_expire) begin
                    state_d = RESP;
                    rdata_d = '0;
`ifdef BUS_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
                stale_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            stale_q     <= 1'b0;
            inv_valid_q <= 1'b0;
            inv_addr_q  <= '0;
`ifdef BUS_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            stale_q     <= stale_d;
            inv_valid_q <= inv_valid_d;
            inv_addr_q  <= inv_addr_d;
`ifdef BUS_TIMEOUT_EN
            err_q       <= err_d;
`endif
        end
    end

    // Ready is masked while rst is held so it rises only after release.
    assign cpu_req_ready  = (state_q == IDLE) && !rst;

    assign bus_access     = in_req;
    assign cache_write    = in_req && we_q;
    assign read_address   = (in_req && !we_q) ? addr_q  : '0;
    assign write_address  = (in_req &&  we_q) ? addr_q  : '0;
    assign write_data     = (in_req &&  we_q) ? wdata_q : '0;

    assign cpu_resp_valid = in_resp;
    assign cpu_resp_rdata = in_resp ? rdata_q : '0;
    assign cpu_resp_stale = in_resp && stale_q;

    assign inv_valid      = inv_valid_q;
    assign inv_addr       = inv_addr_q;

endmodule
